// File: rtl/tk2000_clkgen_if.sv
// Control and strobe bundle between the clock/reset sequencer and the TK2000 core.
// The sequencer sits on the slave modport; the PLL/OSD side and the core use master.
interface tk2000_clkgen_if;
  logic       pll_locked;
  logic       reset_req;
  logic       sys_reset_n;
  logic       ce_14m;
  logic       ce_7m;
  logic       phi0;
  logic       q3;
  logic       cpu_ce;
  logic [6:0] hcount;

  modport slave (
    input  pll_locked, reset_req,
    output sys_reset_n, ce_14m, ce_7m, phi0, q3, cpu_ce, hcount
  );

  modport master (
    output pll_locked, reset_req,
    input  sys_reset_n, ce_14m, ce_7m, phi0, q3, cpu_ce, hcount
  );
endinterface

// File: rtl/tk2000_clkgen.sv
// Lock-qualified reset sequencer and single-clock strobe generator for the TK2000 core:
// 14M/7M enables, PHI0/Q3 levels, CPU clock-enable and the 65-cycle line counter.
module tk2000_clkgen #(
  parameter int LOCK_HOLD  = 1024,
  parameter int SHORT_LEN  = 14,
  parameter int LONG_EXTRA = 2
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  tk2000_clkgen_if.slave   bus
);

  localparam int HW = $clog2(LOCK_HOLD);
  localparam int CW = $clog2(SHORT_LEN + LONG_EXTRA);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LOCK_HOLD - 1);
  localparam logic [CW-1:0] HALF      = CW'(SHORT_LEN / 2);
  localparam logic [CW-1:0] Q3_LO     = CW'(4);
  localparam logic [CW-1:0] Q3_HI     = CW'(SHORT_LEN / 2 + 4);
  localparam logic [CW-1:0] LAST_N    = CW'(SHORT_LEN - 1);
  localparam logic [CW-1:0] LAST_L    = CW'(SHORT_LEN + LONG_EXTRA - 1);
  localparam logic [6:0]    HC_LONG   = 7'd64;

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  state_t          state;
  logic            lock_s1, lock_s2;
  logic [HW-1:0]   hold_cnt;
  logic            sys_reset_n;

  logic            ph, tog7;
  logic [CW-1:0]   c14;
  logic [6:0]      hcount;
  logic            ce_14m, ce_7m, cpu_ce, phi0, q3;

  logic            run;
  logic [CW-1:0]   c14_last;
  logic            q3_nxt;

  // Strobes only advance while the sequencer stays in RUN across this edge.
  assign run      = (state == RUN) && lock_s2 && !bus.reset_req;
  assign c14_last = (hcount == HC_LONG) ? LAST_L : LAST_N;
  // Ticks at or beyond SHORT_LEN fall outside both windows, so the long cycle keeps q3 low.
  assign q3_nxt   = (c14 < Q3_LO) || ((c14 >= HALF) && (c14 < Q3_HI));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1     <= 1'b0;
      lock_s2     <= 1'b0;
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      sys_reset_n <= 1'b0;
    end else begin
      lock_s1 <= bus.pll_locked;
      lock_s2 <= lock_s1;
      if (!lock_s2) begin
        state       <= WAIT_LOCK;
        hold_cnt    <= '0;
        sys_reset_n <= 1'b0;
      end else if (bus.reset_req) begin
        state       <= HOLD;
        hold_cnt    <= '0;
        sys_reset_n <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state       <= RUN;
              sys_reset_n <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: sys_reset_n <= 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ph     <= 1'b0;
      tog7   <= 1'b0;
      c14    <= '0;
      hcount <= '0;
      ce_14m <= 1'b0;
      ce_7m  <= 1'b0;
      cpu_ce <= 1'b0;
      phi0   <= 1'b0;
      q3     <= 1'b0;
    end else if (!run) begin
      ph     <= 1'b0;
      tog7   <= 1'b0;
      c14    <= '0;
      hcount <= '0;
      ce_14m <= 1'b0;
      ce_7m  <= 1'b0;
      cpu_ce <= 1'b0;
      phi0   <= 1'b0;
      q3     <= 1'b0;
    end else begin
      ph     <= ~ph;
      ce_14m <= ph;
      ce_7m  <= ph & ~tog7;
      cpu_ce <= ph && (c14 == c14_last);
      // Levels follow c14 one clk late, i.e. they move on the edge closing a ce_14m cycle.
      phi0   <= (c14 >= HALF);
      q3     <= q3_nxt;
      if (ph) begin
        tog7 <= ~tog7;
        if (c14 == c14_last) begin
          c14    <= '0;
          hcount <= (hcount == HC_LONG) ? 7'd0 : hcount + 7'd1;
        end else begin
          c14 <= c14 + CW'(1);
        end
      end
    end
  end

  assign bus.sys_reset_n = sys_reset_n;
  assign bus.ce_14m      = ce_14m;
  assign bus.ce_7m       = ce_7m;
  assign bus.cpu_ce      = cpu_ce;
  assign bus.phi0        = phi0;
  assign bus.q3          = q3;
  assign bus.hcount      = hcount;

endmodule

// File: tb/tb_tk2000_clkgen.sv
// Randomized bench: a time-based reference model queues the expected outputs for every
// clk; a negedge monitor pops and compares them, and also checks cpu_ce spacing.
module tb_tk2000_clkgen;
  localparam int LH   = 16;
  localparam int SL   = 14;
  localparam int LX   = 2;
  localparam int NRM  = 64 * SL;
  localparam int LINE = NRM + SL + LX;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  tk2000_clkgen_if bus();

  tk2000_clkgen #(.LOCK_HOLD(LH), .SHORT_LEN(SL), .LONG_EXTRA(LX)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic       srn;
    logic       ce14;
    logic       ce7;
    logic       phi0;
    logic       q3;
    logic       cpuce;
    logic [6:0] hc;
  } outs_t;

  typedef enum {M_WAIT, M_HOLD, M_RUN} mode_t;

  outs_t  exp_q[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  int     n_tmo  = 0;

  // Outputs t clks after sys_reset_n rose, from tick counts: a line is LINE 14M ticks,
  // 64 cycles of SL ticks then one of SL+LX ticks.
  function automatic outs_t model(input longint t);
    outs_t  o;
    longint m, q, mp, qp, c;
    o      = '0;
    m      = t / 2;
    q      = m % LINE;
    o.srn  = 1'b1;
    o.hc   = 7'((q < NRM) ? q / SL : 64);
    o.ce14 = (t >= 2) && (t % 2 == 0);
    o.ce7  = (t >= 2) && (t % 4 == 2);
    o.cpuce = o.ce14 && (q <= NRM) && (q % SL == 0);
    if (t >= 1) begin
      mp     = (t - 1) / 2;
      qp     = mp % LINE;
      c      = (qp < NRM) ? qp % SL : qp - NRM;
      o.phi0 = (c >= SL / 2);
      o.q3   = (c < SL) && ((c % (SL / 2)) < 4);
    end
    return o;
  endfunction

  always @(posedge clk_sys) begin : ref_model
    static longint cyc = 0;
    static longint hs  = 0;
    static longint rs  = 0;
    static mode_t  md  = M_WAIT;
    static bit     l1  = 1'b0;
    static bit     l2  = 1'b0;
    bit    lk;
    outs_t e;
    cyc++;
    if (!reset_n) begin
      md = M_WAIT;
      l1 = 1'b0;
      l2 = 1'b0;
    end else begin
      lk = l2;
      l2 = l1;
      l1 = bus.pll_locked;
      if (!lk) md = M_WAIT;
      else if (bus.reset_req) begin md = M_HOLD; hs = cyc; end
      else if (md == M_WAIT) begin md = M_HOLD; hs = cyc; end
      else if (md == M_HOLD && cyc - hs == LH) begin md = M_RUN; rs = cyc; end
    end
    e = (md == M_RUN) ? model(cyc - rs) : '0;
    exp_q.push_back(e);
  end

  always @(negedge clk_sys) begin : monitor
    static longint mcyc    = 0;
    static longint last_ce = -1;
    outs_t  a, e;
    longint want;
    mcyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!reset_n) e = '0;
      a = {bus.sys_reset_n, bus.ce_14m, bus.ce_7m, bus.phi0, bus.q3, bus.cpu_ce, bus.hcount};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL outputs @%0t: got srn=%b ce14=%b ce7=%b phi0=%b q3=%b cpu_ce=%b hc=%0d, want srn=%b ce14=%b ce7=%b phi0=%b q3=%b cpu_ce=%b hc=%0d",
                    $time, a.srn, a.ce14, a.ce7, a.phi0, a.q3, a.cpuce, a.hc,
                    e.srn, e.ce14, e.ce7, e.phi0, e.q3, e.cpuce, e.hc);
      if (a.srn !== 1'b1) last_ce = -1;
      else if (a.cpuce === 1'b1) begin
        if (last_ce >= 0) begin
          want = (a.hc == 7'd0) ? 2 * (SL + LX) : 2 * SL;
          n_chk++;
          if (mcyc - last_ce == want) n_pass++;
          else $display("FAIL cpu_ce_spacing @%0t: got %0d clk, want %0d clk (hc=%0d)",
                        $time, mcyc - last_ce, want, a.hc);
        end
        last_ce = mcyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic wait_for(input int h, input bit need_phi0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      tick(1);
      if (bus.sys_reset_n && bus.hcount == 7'(h) && (!need_phi0 || bus.phi0)) ok = 1'b1;
    end
    if (!ok) begin
      n_tmo++;
      $display("FAIL wait_hcount: hcount stuck at %0d, wanted %0d within 4000 clk", bus.hcount, h);
    end
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    bus.reset_req  = 1'b0;
    reset_n        = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      bus.pll_locked = 1'($urandom_range(0, 1));
    end
    bus.pll_locked = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(12);
    bus.pll_locked = 1'b1;
    tick(6000);
    wait_for(30, 1'b0);
    bus.pll_locked = 1'b0;
    tick($urandom_range(3, 10));
    bus.pll_locked = 1'b1;
    tick(2000);
    wait_for(64, 1'b1);
    bus.reset_req = 1'b1;
    tick(1);
    bus.reset_req = 1'b0;
    tick(2000);
    repeat (25) begin
      case ($urandom_range(0, 3))
        0: begin bus.reset_req = 1'b1;  tick($urandom_range(1, 20)); bus.reset_req = 1'b0;  end
        1: begin bus.pll_locked = 1'b0; tick($urandom_range(1, 30)); bus.pll_locked = 1'b1; end
        2: begin reset_n = 1'b0;        tick($urandom_range(1, 5));  reset_n = 1'b1;        end
        default: ;
      endcase
      tick($urandom_range(20, 2500));
    end
    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_chk + n_tmo);
    $finish;
  end
endmodule
